pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/call_stack.sv | 47 ++++
 rtl/pc_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch-type encoding from instruction decode and
// the program-counter sequencer state enumeration.
// Ports: none (package).
package cpu_pkg;

  localparam int BR_W = 3;

  // Branch/control-flow class produced by decode. Codes 6 and 7 are unused
  // and behave as NONE in the sequencer.
  typedef enum logic [BR_W-1:0] {
    BR_NONE = 3'd0,
    BR_JMP  = 3'd1,
    BR_JZ   = 3'd2,
    BR_JC   = 3'd3,
    BR_CALL = 3'd4,
    BR_RET  = 3'd5
  } br_type_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } seq_state_e;

endpackage

// File: rtl/call_stack.sv
// LIFO return-address stack, DEPTH entries of W bits.
// Ports: push/pop strobes (ignored when full/empty respectively), din pushed
// value, dout current top entry (valid when !empty), full/empty status.
module call_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  // One extra bit so that "DEPTH entries used" is distinguishable from empty.
  logic [PTR_W:0]   sp;
  logic [PTR_W-1:0] top_idx;

  assign top_idx = PTR_W'(sp - 1'b1);
  assign full    = (sp == (PTR_W+1)'(DEPTH));
  assign empty   = (sp == '0);
  assign dout    = mem[top_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

  // Storage needs no reset: entries above sp are never read.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp[PTR_W-1:0]] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: two-cycle FETCH/EXEC instruction cycle with
// free-run and single-step modes, branches, call/return stack and halt.
// Ports: run/step/resume control, br_type/br_target/halt_instr from decode,
// alu_zero/alu_carry flags; pc (registered ROM address), exec_en strobe,
// halted, sticky stk_ovf/stk_unf, step_done pulse.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  input  logic              resume,
  input  logic [BR_W-1:0]   br_type,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              halt_instr,
  input  logic              alu_zero,
  input  logic              alu_carry,
  output logic [ADDR_W-1:0] pc,
  output logic              exec_en,
  output logic              halted,
  output logic              stk_ovf,
  output logic              stk_unf,
  output logic              step_done
);

  seq_state_e        state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pc_inc;
  logic              step_done_nxt;
  logic              ovf_set, unf_set;
  logic              stk_push, stk_pop;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_full, stk_empty;

  // Natural ADDR_W-bit wrap: all-ones + 1 -> 0, also for the pushed return.
  assign pc_inc = pc + 1'b1;

  call_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pc_inc),
    .dout  (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      pc        <= '0;
      step_done <= 1'b0;
      stk_ovf   <= 1'b0;
      stk_unf   <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      step_done <= step_done_nxt;
      if (ovf_set) stk_ovf <= 1'b1;
      if (unf_set) stk_unf <= 1'b1;
    end
  end

  assign halted = (state == ST_HALTED);

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    step_done_nxt = 1'b0;
    ovf_set       = 1'b0;
    unf_set       = 1'b0;
    stk_push      = 1'b0;
    stk_pop       = 1'b0;
    exec_en       = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // step only matters when run=0; run=1 starts fetching anyway.
        if (run || step) state_nxt = ST_FETCH;
      end

      ST_FETCH: begin
        state_nxt = ST_EXEC;
      end

      ST_EXEC: begin
        exec_en = !halt_instr;
        // Normal completion path; overridden below for any halting case.
        state_nxt     = run ? ST_FETCH : ST_IDLE;
        step_done_nxt = !run;
        if (halt_instr) begin
          state_nxt     = ST_HALTED;
          step_done_nxt = 1'b0;
        end else begin
          case (br_type)
            BR_JMP:  pc_nxt = br_target;
            BR_JZ:   pc_nxt = alu_zero  ? br_target : pc_inc;
            BR_JC:   pc_nxt = alu_carry ? br_target : pc_inc;
            BR_CALL: begin
              if (stk_full) begin
                ovf_set       = 1'b1;
                state_nxt     = ST_HALTED;
                step_done_nxt = 1'b0;
              end else begin
                stk_push = 1'b1;
                pc_nxt   = br_target;
              end
            end
            BR_RET: begin
              if (stk_empty) begin
                unf_set       = 1'b1;
                state_nxt     = ST_HALTED;
                step_done_nxt = 1'b0;
              end else begin
                stk_pop = 1'b1;
                pc_nxt  = stk_top;
              end
            end
            default: pc_nxt = pc_inc;
          endcase
        end
      end

      ST_HALTED: begin
        // Resume skips past the halting instruction.
        if (resume) begin
          pc_nxt    = pc_inc;
          state_nxt = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
